// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake body controller and its next-head logic.
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    // Cell coordinate packed as {x[3:0], y[3:0]}
    typedef logic [7:0] coord_t;

    localparam logic [3:0] GRID_MAX = 4'd15;

    function automatic dir_t opposite(input dir_t d);
        dir_t r;
        case (d)
            UP:      r = DOWN;
            DOWN:    r = UP;
            LEFT:    r = RIGHT;
            default: r = LEFT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_body_ctrl_if.sv
// Control/status bundle between the game FSM (master) and the snake body controller (slave).
interface snake_body_ctrl_if #(
    parameter int MAX_LENGTH = 50
) ();
    import snake_pkg::*;

    logic   move_tick;
    dir_t   direction;
    logic   grow;
    logic   restart;
    coord_t body [MAX_LENGTH];
    logic [7:0] curr_length;
    logic   dead;
    logic   moved;

    modport master (
        output move_tick, direction, grow, restart,
        input  body, curr_length, dead, moved
    );

    modport slave (
        input  move_tick, direction, grow, restart,
        output body, curr_length, dead, moved
    );

endinterface

// File: rtl/snake_next_head.sv
// Combinational next-head computation with wall detection; the grid does not wrap.
module snake_next_head
    import snake_pkg::*;
(
    input  coord_t head,
    input  dir_t   dir,
    output coord_t next_head,
    output logic   wall_hit
);

    logic [3:0] x;
    logic [3:0] y;

    assign x = head[7:4];
    assign y = head[3:0];

    always_comb begin
        next_head = head;
        wall_hit  = 1'b0;
        case (dir)
            UP: begin
                if (y == 4'd0) wall_hit = 1'b1;
                else           next_head = {x, y - 4'd1};
            end
            DOWN: begin
                if (y == GRID_MAX) wall_hit = 1'b1;
                else               next_head = {x, y + 4'd1};
            end
            LEFT: begin
                if (x == 4'd0) wall_hit = 1'b1;
                else           next_head = {x - 4'd1, y};
            end
            default: begin
                if (x == GRID_MAX) wall_hit = 1'b1;
                else               next_head = {x + 4'd1, y};
            end
        endcase
    end

endmodule

// File: rtl/snake_body_ctrl.sv
// Owns the snake segment list: advances, grows and kills the snake on move ticks.
// MAX_LENGTH must match the MAX_LENGTH of the connected interface instance.
module snake_body_ctrl
    import snake_pkg::*;
#(
    parameter int           MAX_LENGTH  = 50,
    parameter int           INIT_LENGTH = 2,
    parameter logic [7:0]   START_HEAD  = 8'h88
) (
    input  logic              clk,
    input  logic              nrst,
    snake_body_ctrl_if.slave  bus
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DEAD = 1'b1;

    logic [0:0] state_q;
    coord_t     body_q [MAX_LENGTH];
    logic [7:0] len_q;
    logic       moved_q;
    logic       grow_pending_q;
    dir_t       last_dir_q;

    dir_t       eff_dir;
    coord_t     next_head;
    logic       wall_hit;
    logic       growing;
    logic       grow_eff;
    logic [7:0] limit;
    logic       self_hit;

    function automatic coord_t init_entry(input int idx);
        coord_t c;
        if (idx == 0)
            c = START_HEAD;
        else if (idx <= INIT_LENGTH)
            c = {START_HEAD[7:4] - 4'(idx), START_HEAD[3:0]};
        else
            c = 8'h00;
        return c;
    endfunction

    // A request that reverses the current heading would fold the snake onto itself
    assign eff_dir  = (bus.direction == opposite(last_dir_q)) ? last_dir_q : bus.direction;
    assign growing  = grow_pending_q | bus.grow;
    assign grow_eff = growing && (len_q < 8'(MAX_LENGTH - 1));
    assign limit    = grow_eff ? len_q : len_q - 8'd1;

    snake_next_head u_next_head (
        .head      (body_q[0]),
        .dir       (eff_dir),
        .next_head (next_head),
        .wall_hit  (wall_hit)
    );

    // Without growth the tail cell vacates this move, so it is excluded from the check
    always_comb begin
        self_hit = 1'b0;
        for (int i = 1; i < MAX_LENGTH; i++) begin
            if ((8'(i) <= limit) && (body_q[i] == next_head))
                self_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= ST_RUN;
            len_q          <= 8'(INIT_LENGTH);
            moved_q        <= 1'b0;
            grow_pending_q <= 1'b0;
            last_dir_q     <= RIGHT;
            for (int i = 0; i < MAX_LENGTH; i++)
                body_q[i] <= init_entry(i);
        end else if (bus.restart) begin
            state_q        <= ST_RUN;
            len_q          <= 8'(INIT_LENGTH);
            moved_q        <= 1'b0;
            grow_pending_q <= 1'b0;
            last_dir_q     <= RIGHT;
            for (int i = 0; i < MAX_LENGTH; i++)
                body_q[i] <= init_entry(i);
        end else if (state_q == ST_RUN) begin
            moved_q <= 1'b0;
            if (bus.grow)
                grow_pending_q <= 1'b1;
            if (bus.move_tick) begin
                if (wall_hit || self_hit) begin
                    state_q <= ST_DEAD;
                end else begin
                    for (int i = 1; i < MAX_LENGTH; i++)
                        body_q[i] <= body_q[i-1];
                    body_q[0]      <= next_head;
                    last_dir_q     <= eff_dir;
                    moved_q        <= 1'b1;
                    grow_pending_q <= 1'b0;
                    if (grow_eff)
                        len_q <= len_q + 8'd1;
                end
            end
        end else begin
            moved_q <= 1'b0;
        end
    end

    assign bus.body        = body_q;
    assign bus.curr_length = len_q;
    assign bus.dead        = (state_q == ST_DEAD);
    assign bus.moved       = moved_q;

endmodule

// File: doc/snake_body_ctrl.md
Name: snake_body_ctrl

Overview:
- Sequential owner of the snake's segment list.
- On each game move tick it computes the next head coordinate from the direction input, checks for wall and self collision, and shifts the body. It grows the snake when an apple has been eaten.
- Drives the `body` array and `curr_length` consumed by the per-pixel location checker, plus the `dead` and `moved` status flags to the game FSM.

Parameters:
- MAX_LENGTH, 50: number of body entries. Entry 0 is the head; usable tail entries are 1..MAX_LENGTH-1.
- INIT_LENGTH, 2: tail segments after reset/restart. Legal range 1..MAX_LENGTH-1.
- START_HEAD, 8'h88: initial head coordinate, encoded {x[3:0], y[3:0]}.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- move_tick  in  1  one-cycle pulse; advance the snake one cell
- direction  in  2  requested heading: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
- grow  in  1  one-cycle pulse; apple eaten, grow on the next move
- restart  in  1  synchronous return to the initial snake
- body  out  MAX_LENGTH x 8  segment coordinates; body[0] is the head
- curr_length  out  8  number of valid tail segments; body[1..curr_length] are valid
- dead  out  1  high after a collision until restart or reset
- moved  out  1  one-cycle pulse in the cycle after a successful move

Behaviour:
- Reset is asynchronous on nrst and synchronous on restart; both produce the same state:
  - body[0] = START_HEAD
  - body[i] = {START_HEAD.x - i, START_HEAD.y} for 1 <= i <= INIT_LENGTH
  - all other entries = 8'h00
  - curr_length = INIT_LENGTH
  - dead = 0, moved = 0, grow_pending = 0, last_dir = right (11)
- restart has priority over move_tick and grow in the same cycle.
- States:
  - RUN: ticks are processed.
  - DEAD: all ticks and grow pulses are ignored, body and curr_length are frozen, dead = 1.
  - RUN -> DEAD on a collision. DEAD -> RUN only on restart or nrst.
- Effective direction:
  - A request that is the exact reverse of last_dir is ignored; last_dir is used instead.
  - Otherwise the request is used, and last_dir is updated on a successful move.
- Wall collision: x = 0 moving left, x = 15 moving right, y = 0 moving up, or y = 15 moving down.
  - No wrap-around.
  - Result: DEAD, no shift, moved stays 0.
- Self collision: next_head equals body[i] for 1 <= i <= limit.
  - limit = curr_length - 1 if no growth this move, because the tail cell vacates.
  - limit = curr_length if growing.
  - Result: DEAD, no shift.
- Successful move, applied on the clock edge where move_tick = 1:
  - body[i] <= body[i-1] for i = 1..MAX_LENGTH-1
  - body[0] <= next_head
  - moved = 1 for exactly the following cycle
- Growth:
  - grow sets grow_pending.
  - A successful move with grow_pending (or grow asserted in the same cycle) increments curr_length and clears grow_pending.
  - At curr_length = MAX_LENGTH-1 the length saturates: the move proceeds as a normal shift and the request is dropped and cleared.
- Latency: body, curr_length, dead and moved are registered and valid one cycle after the move_tick edge. No combinational path exists from inputs to outputs.
- A grow pulse without move_tick only sets grow_pending; body is unchanged.
- A move_tick arriving while moved is still high is processed normally (back-to-back ticks are legal).

Decomposition:
- Package snake_pkg:
  - dir_t enum (UP, DOWN, LEFT, RIGHT)
  - coord_t typedef (8-bit {x, y})
  - GRID_MAX = 15
  - function opposite(dir_t)
- Sub-module snake_next_head (combinational): inputs head and dir_t; outputs next_head and wall_hit.

Test Plan:
- Reset with defaults -> body[0] = 88, body[1] = 78, body[2] = 68, curr_length = 2, dead = 0. Apply move_tick with dir = right -> next cycle body[0] = 98, body[1] = 88, body[2] = 78, moved = 1 for one cycle.
- Head at 88 heading right, then dir = left + move_tick -> reversal ignored; body[0] = 98.
- grow pulse, then move_tick up from head 88 -> body[0] = 87, curr_length = 3, body[3] = 68. Repeat with grow and move_tick in the same cycle -> identical result.
- Head at F5 moving right + move_tick -> dead = 1, body unchanged. Further ticks ignored. restart -> initial state, dead = 0.
- Length 4 snake coiled so next_head equals the tail cell, no grow -> move succeeds. Same position with grow pending -> dead = 1.
- MAX_LENGTH = 4, grow pulses until curr_length = 3, one more grow + move -> curr_length stays 3, shift occurs, grow_pending cleared. Assert nrst mid-run -> outputs return to initial values asynchronously.
